// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents:
//   - default address/data widths,
//   - owner encoding (which requester holds the port),
//   - FSM state encoding,
//   - width of the starvation counter.
// No ports: this is a package imported by mem_arb_pick and mem_port_arbiter.
package mem_arb_pkg;

  localparam int unsigned DefaultAw = 8;
  localparam int unsigned DefaultDw = 8;

  // Wide enough for the largest legal STARVE_MAX (15).
  localparam int unsigned StarveW = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2,
    OWN_LDR   = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory port arbiter.
// Fixed priority loader > data > fetch. A starved fetch (starved=1 while fetch_req=1)
// overrides the fixed order and wins.
// Ports:
//   fetch_req, data_req, ldr_req  in   pending requests
//   starved                       in   starvation counter has reached its limit
//   owner                         out  winner code (mem_arb_pkg::owner_e encoding)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       ldr_req,
  input  logic       starved,
  output logic [1:0] owner
);

  always_comb begin
    owner = OWN_NONE;
    if (starved && fetch_req) begin
      owner = OWN_FETCH;
    end else if (ldr_req) begin
      owner = OWN_LDR;
    end else if (data_req) begin
      owner = OWN_DATA;
    end else if (fetch_req) begin
      owner = OWN_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch, data load/store and
// the external loader. Each access takes three cycles: IDLE (grant, register address/wdata/we),
// XFER (memory access, read data captured at its closing edge), ACK (one-cycle ack pulse to
// the owner). The CPU side stalls until its ack arrives.
//
// Optional feature: define MEM_ARB_STATS_EN to add grant and stall counters.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   fetch_req/fetch_addr           instruction fetch (read only)
//   data_req/data_we/addr/wdata    CPU load/store
//   ldr_req/ldr_we/addr/wdata      external loader
//   fetch_ack, data_ack, ldr_ack   one-cycle completion pulses
//   rdata                          read data, valid while an ack is high, otherwise held
//   mem_addr, mem_wdata, mem_we    registered memory controls
//   mem_rdata                      combinational memory read data for mem_addr
//   busy                           access in progress (XFER or ACK)
//   stat_fetch/data/ldr, stat_stall  grant and stall counters (MEM_ARB_STATS_EN only)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = DefaultAw,
  parameter int unsigned DW         = DefaultDw,
  parameter int unsigned STARVE_MAX = 4
`ifdef MEM_ARB_STATS_EN
  ,
  parameter int unsigned STAT_W     = 16
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          fetch_ack,
  output logic          data_ack,
  output logic          ldr_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_fetch,
  output logic [STAT_W-1:0] stat_data,
  output logic [STAT_W-1:0] stat_ldr,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  localparam logic [StarveW-1:0] StarveMaxC = StarveW'(STARVE_MAX);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [StarveW-1:0]   starve_q, starve_d;

  logic [1:0]           pick_raw;
  owner_e               pick;
  logic                 starved;

  assign starved = (starve_q == StarveMaxC);

  mem_arb_pick u_pick (
    .fetch_req (fetch_req),
    .data_req  (data_req),
    .ldr_req   (ldr_req),
    .starved   (starved),
    .owner     (pick_raw)
  );

  assign pick = owner_e'(pick_raw);

  // Next-state logic. Requests are only looked at in IDLE, so an owner still holding its req
  // during ACK cannot be granted twice.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    rdata_d  = rdata_q;
    starve_d = starve_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!fetch_req) begin
          starve_d = '0;
        end
        if (pick != OWN_NONE) begin
          state_d = ST_XFER;
          owner_d = pick;
          unique case (pick)
            OWN_FETCH: begin
              addr_d = fetch_addr;
              we_d   = 1'b0;
            end
            OWN_DATA: begin
              addr_d  = data_addr;
              wdata_d = data_wdata;
              we_d    = data_we;
            end
            OWN_LDR: begin
              addr_d  = ldr_addr;
              wdata_d = ldr_wdata;
              we_d    = ldr_we;
            end
            default: ;
          endcase
          // A fetch grant resets starvation; any other grant while fetch waits counts a loss.
          if (pick == OWN_FETCH) begin
            starve_d = '0;
          end else if (fetch_req && !starved) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      ST_XFER: begin
        // Memory performs the write on this same closing edge; we_d default drops mem_we.
        rdata_d = mem_rdata;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      starve_q <= starve_d;
    end
  end

  assign fetch_ack = (state_q == ST_ACK) && (owner_q == OWN_FETCH);
  assign data_ack  = (state_q == ST_ACK) && (owner_q == OWN_DATA);
  assign ldr_ack   = (state_q == ST_ACK) && (owner_q == OWN_LDR);
  assign busy      = (state_q != ST_IDLE);
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_fetch_q, stat_data_q, stat_ldr_q, stat_stall_q;
  logic              grant;
  logic              stall;

  assign grant = (state_q == ST_IDLE) && (pick != OWN_NONE);
  // One count per cycle in which the CPU side is waiting, regardless of how many ports wait.
  assign stall = (fetch_req && !fetch_ack) || (data_req && !data_ack);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_fetch_q <= '0;
      stat_data_q  <= '0;
      stat_ldr_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      if (grant && (pick == OWN_FETCH)) stat_fetch_q <= stat_fetch_q + 1'b1;
      if (grant && (pick == OWN_DATA))  stat_data_q  <= stat_data_q + 1'b1;
      if (grant && (pick == OWN_LDR))   stat_ldr_q   <= stat_ldr_q + 1'b1;
      if (stall)                        stat_stall_q <= stat_stall_q + 1'b1;
    end
  end

  assign stat_fetch = stat_fetch_q;
  assign stat_data  = stat_data_q;
  assign stat_ldr   = stat_ldr_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Directed stimulus pushes the expected
// acknowledgements (owner, address, read data) into a queue in grant order; a monitor on the
// falling edge pops and compares each time an ack is presented. A small memory model sits on
// the mem_* port.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req, data_req, data_we, ldr_req, ldr_we;
  logic [AW-1:0] fetch_addr, data_addr, ldr_addr;
  logic [DW-1:0] data_wdata, ldr_wdata;
  logic          fetch_ack, data_ack, ldr_ack, mem_we, busy;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]   stat_fetch, stat_data, stat_ldr, stat_stall;
`endif

  mem_port_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .fetch_ack  (fetch_ack),
    .data_ack   (data_ack),
    .ldr_ack    (ldr_ack),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_fetch (stat_fetch),
    .stat_data  (stat_data),
    .stat_ldr   (stat_ldr),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  logic [DW-1:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  typedef struct packed {
    logic [1:0]    own;
    logic [AW-1:0] addr;
    logic          chk_rd;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   we_cycles = 0;
  int   n_f, n_d, n_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] own_of(input logic [2:0] acks);
    case (acks)
      3'b001:  return 2'd1;
      3'b010:  return 2'd2;
      3'b100:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic push(input logic [1:0] own, input logic [AW-1:0] a, input logic chk,
                      input logic [DW-1:0] rd);
    exp_t x;
    x.own = own; x.addr = a; x.chk_rd = chk; x.rd = rd;
    sb.push_back(x);
  endtask

  // Monitor: every presented ack is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we) we_cycles++;
    if ({ldr_ack, data_ack, fetch_ack} != 3'b000) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {29'd0, ldr_ack, data_ack, fetch_ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_owner", {30'd0, own_of({ldr_ack, data_ack, fetch_ack})}, {30'd0, e.own});
        check("ack_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        if (e.chk_rd) check("ack_rdata", {24'd0, rdata}, {24'd0, e.rd});
      end
    end
  end

  // Requester tasks: called just after a falling edge; return the number of falling edges
  // until the ack was seen, then drop req inside the ACK cycle.
  task automatic fetch_op(input logic [AW-1:0] a, output int n);
    fetch_addr = a; fetch_req = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!fetch_ack && n < 40);
    check("fetch_ack_seen", {31'd0, fetch_ack}, 32'd1);
    fetch_req = 1'b0;
  endtask

  task automatic data_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         output int n);
    data_we = we; data_addr = a; data_wdata = wd; data_req = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!data_ack && n < 40);
    check("data_ack_seen", {31'd0, data_ack}, 32'd1);
    data_req = 1'b0;
  endtask

  task automatic ldr_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        output int n);
    ldr_we = we; ldr_addr = a; ldr_wdata = wd; ldr_req = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!ldr_ack && n < 40);
    check("ldr_ack_seen", {31'd0, ldr_ack}, 32'd1);
    ldr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int we0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h30] = 8'h11;
    mem[8'h31] = 8'h22;
    mem[8'h32] = 8'h33;

    // 1. Reset with every request asserted.
    rst_n = 1'b0;
    fetch_req = 1'b1; data_req = 1'b1; ldr_req = 1'b1;
    data_we = 1'b1; ldr_we = 1'b1;
    fetch_addr = 8'h01; data_addr = 8'h02; ldr_addr = 8'h03;
    data_wdata = 8'hFF; ldr_wdata = 8'hEE;
    repeat (3) @(negedge clk);
    check("rst_acks", {29'd0, ldr_ack, data_ack, fetch_ack}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    fetch_req = 1'b0; data_req = 1'b0; ldr_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 2. Fetch read with latency check.
    we0 = we_cycles;
    push(2'd1, 8'h10, 1'b1, 8'hA5);
    fetch_addr = 8'h10; fetch_req = 1'b1;
    @(negedge clk);
    check("fetch_xfer_addr", {24'd0, mem_addr}, 32'h10);
    check("fetch_xfer_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("fetch_ack_at_2", {31'd0, fetch_ack}, 32'd1);
    fetch_req = 1'b0;
    @(negedge clk);
    check("fetch_no_we", we_cycles - we0, 32'd0);

    // 3. Store then load.
    we0 = we_cycles;
    push(2'd2, 8'h20, 1'b0, 8'h00);
    data_op(1'b1, 8'h20, 8'h3C, n_d);
    check("store_we_cycles", we_cycles - we0, 32'd1);
    check("store_mem", {24'd0, mem[8'h20]}, 32'h3C);
    @(negedge clk);
    push(2'd2, 8'h20, 1'b1, 8'h3C);
    data_op(1'b0, 8'h20, 8'h00, n_d);
    check("load_latency", n_d, 32'd2);
    @(negedge clk);

    // 4. Three-way contention: ldr, data, fetch, acks three cycles apart.
    push(2'd3, 8'h30, 1'b1, 8'h11);
    push(2'd2, 8'h31, 1'b1, 8'h22);
    push(2'd1, 8'h32, 1'b1, 8'h33);
    fork
      ldr_op(1'b0, 8'h30, 8'h00, n_l);
      data_op(1'b0, 8'h31, 8'h00, n_d);
      fetch_op(8'h32, n_f);
    join
    check("cont_ldr_lat", n_l, 32'd2);
    check("cont_data_lat", n_d, 32'd5);
    check("cont_fetch_lat", n_f, 32'd8);
    @(negedge clk);

    // 5. Starvation: four data grants, then the waiting fetch wins over a fifth data request.
    for (int i = 0; i < 4; i++) push(2'd2, 8'h31, 1'b1, 8'h22);
    push(2'd1, 8'h10, 1'b1, 8'hA5);
    push(2'd2, 8'h31, 1'b1, 8'h22);
    fork
      fetch_op(8'h10, n_f);
      begin
        for (int i = 0; i < 5; i++) begin
          data_op(1'b0, 8'h31, 8'h00, n_d);
          @(negedge clk);
        end
      end
    join
    check("starve_fetch_lat", n_f, 32'd14);
    check("starve_last_data_lat", n_d, 32'd5);
    // Counter cleared: data wins the next contention again.
    push(2'd2, 8'h31, 1'b1, 8'h22);
    push(2'd1, 8'h32, 1'b1, 8'h33);
    fork
      data_op(1'b0, 8'h31, 8'h00, n_d);
      fetch_op(8'h32, n_f);
    join
    check("post_starve_data_lat", n_d, 32'd2);
    check("post_starve_fetch_lat", n_f, 32'd5);
    @(negedge clk);

    // 6. Reset during the XFER of a store.
    data_we = 1'b1; data_addr = 8'h50; data_wdata = 8'h99; data_req = 1'b1;
    @(negedge clk);
    check("midrst_xfer_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0; data_req = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_we", {31'd0, mem_we}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rdata", {24'd0, rdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", {31'd0, busy}, 32'd0);
`ifdef MEM_ARB_STATS_EN
    check("stat_fetch_rst", {16'd0, stat_fetch}, 32'd0);
    check("stat_data_rst", {16'd0, stat_data}, 32'd0);
    check("stat_ldr_rst", {16'd0, stat_ldr}, 32'd0);
    check("stat_stall_rst", {16'd0, stat_stall}, 32'd0);
`endif
    push(2'd2, 8'h60, 1'b0, 8'h00);
    data_op(1'b1, 8'h60, 8'h5A, n_d);
    check("after_rst_store_lat", n_d, 32'd2);
    @(negedge clk);
    check("after_rst_mem", {24'd0, mem[8'h60]}, 32'h5A);
`ifdef MEM_ARB_STATS_EN
    check("stat_data_one", {16'd0, stat_data}, 32'd1);
    check("stat_fetch_zero", {16'd0, stat_fetch}, 32'd0);
    check("stat_stall_two", {16'd0, stat_stall}, 32'd2);
`endif
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
